// File: rtl/fft_frame_sched.sv
// Frame-granular round-robin arbiter sharing one FFT core between two sample streams.
// Each granted frame's channel is queued as a tag and attached to the matching result frame.
// Optional macro FFT_SCHED_STATS_EN adds per-channel completed-frame counters.
module fft_frame_sched #(
    parameter int WIDTH     = 16,
    parameter int NPTS      = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_push,
    input  logic signed [WIDTH-1:0] req0_real,
    input  logic signed [WIDTH-1:0] req0_imag,
    output logic                    req0_stall,
    input  logic                    req1_push,
    input  logic signed [WIDTH-1:0] req1_real,
    input  logic signed [WIDTH-1:0] req1_imag,
    output logic                    req1_stall,
    output logic                    fft_push,
    output logic signed [WIDTH-1:0] fft_real,
    output logic signed [WIDTH-1:0] fft_imag,
    input  logic                    fft_stall,
    input  logic                    fft_out_push,
    input  logic signed [WIDTH-1:0] fft_out_real,
    input  logic signed [WIDTH-1:0] fft_out_imag,
    output logic                    fft_out_stall,
    output logic                    out_push,
    output logic signed [WIDTH-1:0] out_real,
    output logic signed [WIDTH-1:0] out_imag,
    output logic                    out_chan,
    input  logic                    out_stall,
`ifdef FFT_SCHED_STATS_EN
    output logic [15:0]             stat_frames0,
    output logic [15:0]             stat_frames1,
`endif
    output logic                    err
);

    localparam int CW   = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam int PW   = $clog2(TAG_DEPTH);
    localparam int CNTW = PW + 1;
    localparam logic [CW-1:0]   LAST_IDX = CW'(NPTS - 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(TAG_DEPTH);

    typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

    state_t state_q, state_d;

    logic                 grant_q, last_q;
    logic [CW-1:0]        in_cnt_q, out_cnt_q;
    logic [TAG_DEPTH-1:0] tag_q;
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]      count_q;
    logic                 err_q;

    logic tag_full, tag_empty, head_chan;
    logic grant_sel, can_grant, start;
    logic in_accept, frame_done, out_accept, out_done;

    assign tag_full  = (count_q == FULL_CNT);
    assign tag_empty = (count_q == '0);
    assign head_chan = tag_empty ? 1'b0 : tag_q[rd_ptr_q];

    // Contention goes to the channel that did not win last time.
    assign grant_sel  = (req0_push && req1_push) ? ~last_q : req1_push;
    assign can_grant  = (req0_push || req1_push) && !tag_full;
    assign start      = (state_q == IDLE) && can_grant;
    assign in_accept  = (state_q == FRAME) && fft_push && !fft_stall;
    assign frame_done = in_accept && (in_cnt_q == LAST_IDX);
    assign out_accept = out_push && !out_stall;
    assign out_done   = out_accept && (out_cnt_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (can_grant) state_d = FRAME;
            FRAME:   if (frame_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_stall = 1'b1;
        req1_stall = 1'b1;
        fft_push   = 1'b0;
        fft_real   = '0;
        fft_imag   = '0;
        if (state_q == FRAME) begin
            if (grant_q) begin
                fft_push   = req1_push;
                fft_real   = req1_real;
                fft_imag   = req1_imag;
                req1_stall = fft_stall;
            end else begin
                fft_push   = req0_push;
                fft_real   = req0_real;
                fft_imag   = req0_imag;
                req0_stall = fft_stall;
            end
        end
    end

    assign out_push      = fft_out_push && !tag_empty;
    assign fft_out_stall = out_stall || tag_empty;
    assign out_real      = fft_out_real;
    assign out_imag      = fft_out_imag;
    assign out_chan      = head_chan;
    assign err           = err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            tag_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (start) begin
                grant_q         <= grant_sel;
                last_q          <= grant_sel;
                in_cnt_q        <= '0;
                tag_q[wr_ptr_q] <= grant_sel;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (in_accept) begin
                in_cnt_q <= frame_done ? '0 : in_cnt_q + CW'(1);
            end
            if (out_accept) begin
                out_cnt_q <= out_done ? '0 : out_cnt_q + CW'(1);
            end
            if (out_done) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            // Grant and frame-end on the same edge cancel out in the count.
            case ({start, out_done})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
            if (fft_out_push && tag_empty) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef FFT_SCHED_STATS_EN
    logic [15:0] stat0_q, stat1_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else if (out_done) begin
            if (head_chan) begin
                stat1_q <= stat1_q + 16'd1;
            end else begin
                stat0_q <= stat0_q + 16'd1;
            end
        end
    end

    assign stat_frames0 = stat0_q;
    assign stat_frames1 = stat1_q;
`endif

endmodule

// File: tb/tb_fft_frame_sched.sv
// Bench for fft_frame_sched: the bench plays both producers, the FFT core and the sink,
// and checks every cycle against a frame/tag-queue reference model.
`timescale 1ns/1ps
module tb_fft_frame_sched;

    localparam int WIDTH     = 16;
    localparam int NPTS      = 16;
    localparam int TAG_DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    reset;
    logic                    req0_push, req1_push;
    logic signed [WIDTH-1:0] req0_real, req0_imag, req1_real, req1_imag;
    logic                    req0_stall, req1_stall;
    logic                    fft_push;
    logic signed [WIDTH-1:0] fft_real, fft_imag;
    logic                    fft_stall;
    logic                    fft_out_push;
    logic signed [WIDTH-1:0] fft_out_real, fft_out_imag;
    logic                    fft_out_stall;
    logic                    out_push;
    logic signed [WIDTH-1:0] out_real, out_imag;
    logic                    out_chan;
    logic                    out_stall;
    logic                    err;
`ifdef FFT_SCHED_STATS_EN
    logic [15:0]             stat_frames0, stat_frames1;
`endif

    fft_frame_sched #(.WIDTH(WIDTH), .NPTS(NPTS), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_push    (req0_push),
        .req0_real    (req0_real),
        .req0_imag    (req0_imag),
        .req0_stall   (req0_stall),
        .req1_push    (req1_push),
        .req1_real    (req1_real),
        .req1_imag    (req1_imag),
        .req1_stall   (req1_stall),
        .fft_push     (fft_push),
        .fft_real     (fft_real),
        .fft_imag     (fft_imag),
        .fft_stall    (fft_stall),
        .fft_out_push (fft_out_push),
        .fft_out_real (fft_out_real),
        .fft_out_imag (fft_out_imag),
        .fft_out_stall(fft_out_stall),
        .out_push     (out_push),
        .out_real     (out_real),
        .out_imag     (out_imag),
        .out_chan     (out_chan),
        .out_stall    (out_stall),
`ifdef FFT_SCHED_STATS_EN
        .stat_frames0 (stat_frames0),
        .stat_frames1 (stat_frames1),
`endif
        .err          (err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the core, samples taken so far, queue of frame tags.
    bit   m_busy, m_g, m_last, m_err;
    int   m_in, m_out;
    logic exp_tag_q[$];
    logic grant_log[$];
`ifdef FFT_SCHED_STATS_EN
    logic [15:0] m_stat0, m_stat1;
`endif

    int   obs_in_acc, obs_out_n;
    logic obs_tags[$];
    int   txi0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_g = 0; m_last = 1; m_err = 0; m_in = 0; m_out = 0;
        exp_tag_q.delete();
`ifdef FFT_SCHED_STATS_EN
        m_stat0 = '0; m_stat1 = '0;
`endif
    endtask

    function automatic logic signed [WIDTH-1:0] rnd16();
        return WIDTH'($urandom_range(0, 65535));
    endfunction

    // Called just after a falling edge with inputs set; checks, then advances one rising edge.
    task automatic cycle();
        bit   e_fp, e_s0, e_s1, e_op, e_fos, e_pop, e_gnt, sel;
        logic signed [WIDTH-1:0] e_fr, e_fi;
        int   n;
        #1;
        n     = exp_tag_q.size();
        e_fp  = m_busy ? (m_g ? req1_push : req0_push) : 1'b0;
        e_fr  = m_g ? req1_real : req0_real;
        e_fi  = m_g ? req1_imag : req0_imag;
        e_s0  = (m_busy && !m_g) ? fft_stall : 1'b1;
        e_s1  = (m_busy && m_g) ? fft_stall : 1'b1;
        e_op  = fft_out_push && (n > 0);
        e_fos = out_stall || (n == 0);
        chk("req0_stall", req0_stall, e_s0);
        chk("req1_stall", req1_stall, e_s1);
        chk("fft_push", fft_push, e_fp);
        if (e_fp) begin
            chk("fft_real", fft_real, e_fr);
            chk("fft_imag", fft_imag, e_fi);
        end
        chk("out_push", out_push, e_op);
        chk("fft_out_stall", fft_out_stall, e_fos);
        chk("out_real", out_real, fft_out_real);
        chk("out_imag", out_imag, fft_out_imag);
        if (n > 0) chk("out_chan", out_chan, exp_tag_q[0]);
        chk("err", err, m_err);
`ifdef FFT_SCHED_STATS_EN
        chk("stat0", stat_frames0, m_stat0);
        chk("stat1", stat_frames1, m_stat1);
`endif
        if (fft_push && !fft_stall) obs_in_acc++;
        if (out_push && !out_stall) begin
            obs_out_n++;
            if (obs_out_n == NPTS) begin
                obs_tags.push_back(out_chan);
                obs_out_n = 0;
            end
        end
        if (e_fp && !fft_stall && !m_g) txi0++;
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            e_pop = 0;
            e_gnt = 0;
            sel   = 0;
            if (e_op && !out_stall) begin
                m_out++;
                if (m_out == NPTS) begin m_out = 0; e_pop = 1; end
            end
            if (fft_out_push && n == 0) m_err = 1;
            if (m_busy) begin
                if (e_fp && !fft_stall) begin
                    m_in++;
                    if (m_in == NPTS) begin m_in = 0; m_busy = 0; end
                end
            end else if ((req0_push || req1_push) && n < TAG_DEPTH) begin
                sel    = (req0_push && req1_push) ? !m_last : req1_push;
                m_g    = sel;
                m_last = sel;
                m_busy = 1;
                m_in   = 0;
                e_gnt  = 1;
            end
            if (e_pop) begin
`ifdef FFT_SCHED_STATS_EN
                if (exp_tag_q[0]) m_stat1++; else m_stat0++;
`endif
                void'(exp_tag_q.pop_front());
            end
            if (e_gnt) begin
                exp_tag_q.push_back(sel);
                grant_log.push_back(sel);
            end
        end
        @(negedge clk);
    endtask

    // The bench acting as the core: results appear only while some frame is tagged.
    task automatic core_out_rnd();
        fft_out_push = (exp_tag_q.size() > 0) && ($urandom_range(0, 3) != 0);
        fft_out_real = rnd16();
        fft_out_imag = rnd16();
    endtask

    task automatic do_reset();
        req0_push = 0; req1_push = 0; fft_out_push = 0; fft_stall = 0; out_stall = 0;
        reset = 0;
        cycle();
        cycle();
        reset = 1;
        obs_in_acc = 0; obs_out_n = 0; txi0 = 0;
        obs_tags.delete();
        grant_log.delete();
    endtask

    initial begin
        reset = 0;
        req0_push = 0; req1_push = 0; fft_stall = 0; out_stall = 0; fft_out_push = 0;
        req0_real = 0; req0_imag = 0; req1_real = 0; req1_imag = 0;
        fft_out_real = 0; fft_out_imag = 0;
        obs_in_acc = 0; obs_out_n = 0; txi0 = 0;
        model_reset();
        @(negedge clk);
        repeat (2) cycle();
        chk("rst_req0_stall", req0_stall, 1);
        chk("rst_req1_stall", req1_stall, 1);
        chk("rst_fft_push", fft_push, 0);
        chk("rst_out_push", out_push, 0);
        chk("rst_fft_out_stall", fft_out_stall, 1);
        chk("rst_out_chan", out_chan, 0);
        chk("rst_err", err, 0);
        reset = 1;

        // Single producer, impulse frame on channel 0.
        req0_push = 1;
        for (int k = 0; k < 200 && obs_in_acc < NPTS; k++) begin
            req0_real = (txi0 == 0) ? 16'sh7fff : 16'sh0000;
            req0_imag = 0;
            cycle();
        end
        req0_push = 0;
        chk("t1_accepts", obs_in_acc, NPTS);
        for (int k = 0; k < 200 && obs_tags.size() < 1; k++) begin
            fft_out_push = (exp_tag_q.size() > 0);
            fft_out_real = rnd16();
            fft_out_imag = rnd16();
            cycle();
        end
        fft_out_push = 0;
        chk("t1_frames_out", obs_tags.size(), 1);
        if (obs_tags.size() > 0) chk("t1_tag", obs_tags[0], 0);
        chk("t1_err", err, 0);

        // Both producers streaming: alternating grants and tags.
        do_reset();
        req0_push = 1; req1_push = 1;
        for (int k = 0; k < 400 && obs_tags.size() < 4; k++) begin
            req0_real = rnd16(); req0_imag = rnd16();
            req1_real = rnd16(); req1_imag = rnd16();
            core_out_rnd();
            cycle();
        end
        chk("t2_frames_out", obs_tags.size(), 4);
        for (int i = 0; i < 4 && i < obs_tags.size(); i++) chk("t2_tag_order", obs_tags[i], i % 2);

        // Sink blocked: the tag FIFO fills and grants stop.
        do_reset();
        req0_push = 1; req1_push = 1; out_stall = 1;
        for (int k = 0; k < 120; k++) begin
            req0_real = rnd16(); req1_real = rnd16();
            core_out_rnd();
            cycle();
        end
        chk("t3_accepts_full", obs_in_acc, TAG_DEPTH * NPTS);
        chk("t3_req0_blocked", req0_stall, 1);
        chk("t3_req1_blocked", req1_stall, 1);
        out_stall = 0;
        for (int k = 0; k < 300 && obs_in_acc <= TAG_DEPTH * NPTS; k++) begin
            req0_real = rnd16(); req1_real = rnd16();
            core_out_rnd();
            cycle();
        end
        chk("t3_resumed", obs_in_acc > TAG_DEPTH * NPTS, 1);

        // Core input stalls every third cycle.
        do_reset();
        req1_push = 1;
        for (int k = 0; k < 200 && obs_in_acc < NPTS; k++) begin
            fft_stall = (k % 3 == 2);
            req1_real = rnd16(); req1_imag = rnd16();
            cycle();
        end
        req1_push = 0; fft_stall = 0;
        repeat (4) cycle();
        chk("t4_accepts", obs_in_acc, NPTS);

        // Reset in the middle of a frame.
        do_reset();
        req0_push = 1; req1_push = 1;
        for (int k = 0; k < 50 && obs_in_acc < 7; k++) begin
            req0_real = rnd16(); req1_real = rnd16();
            cycle();
        end
        chk("t5_partial", obs_in_acc, 7);
        reset = 0;
        cycle();
        reset = 1;
        chk("t5_req0_stall", req0_stall, 1);
        chk("t5_req1_stall", req1_stall, 1);
        chk("t5_fifo_empty", fft_out_stall, 1);
        cycle();
        chk("t5_req0_granted", req0_stall, 0);
        chk("t5_req1_waits", req1_stall, 1);

        // Randomised traffic on every input.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            req0_push = ($urandom_range(0, 4) != 0);
            req1_push = ($urandom_range(0, 2) != 0);
            req0_real = rnd16(); req0_imag = rnd16();
            req1_real = rnd16(); req1_imag = rnd16();
            fft_stall = ($urandom_range(0, 3) == 0);
            out_stall = ($urandom_range(0, 3) == 0);
            core_out_rnd();
            cycle();
        end

        // Core output with nothing tagged.
        do_reset();
        fft_out_push = 1;
        for (int k = 0; k < 3; k++) begin
            fft_out_real = rnd16(); fft_out_imag = rnd16();
            cycle();
        end
        fft_out_push = 0;
        repeat (5) cycle();
        chk("t6_err_sticky", err, 1);
        chk("t6_no_output", out_push, 0);
`ifdef FFT_SCHED_STATS_EN
        chk("t6_stat0", stat_frames0, 0);
        chk("t6_stat1", stat_frames1, 0);
`endif
        do_reset();
        chk("t6_err_cleared", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
